fifo_rd_ctrl: RTL and testbench

FIFO_RD_CTRL -- requirements
Module: fifo_rd_ctrl

---
 rtl/fifo_rd_ctrl.sv | 54 +++++
 tb/tb_fifo_rd_ctrl.sv | 169 ++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_ctrl.sv
// fifo_rd_ctrl: FIFO read controller with 1-cycle read latency, 2-entry skid buffer and run/drain FSM
module fifo_rd_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_data,
    output logic                  fifo_rd,
    output logic                  out_valid,
    output logic [DATA_WIDTH-1:0] out_data,
    input  logic                  out_ready,
    output logic [7:0]            pop_count,
    output logic [1:0]            state
);
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2} state_t;
    state_t                cur, nxt;
    logic [1:0]            occ, occ_n, base, level;
    logic                  pend, xfer;
    logic [DATA_WIDTH-1:0] head, tail, head_n, tail_n;
    always_comb begin
        state     = cur;
        out_valid = reset && occ != 2'd0;
        out_data  = reset ? head : '0;
        xfer      = out_valid && out_ready;
        level     = occ + {1'b0, pend} - {1'b0, xfer};
        fifo_rd   = reset && cur == RUN && en && !fifo_empty && level < 2'd2;
        occ_n     = level;
        base      = occ - {1'b0, xfer};
        head_n    = pend && base == 2'd0 ? fifo_data : xfer ? tail : head;
        tail_n    = pend && base == 2'd1 ? fifo_data : tail;
        nxt       = en ? RUN :
                    cur == RUN ? ((occ != 2'd0 || pend) ? DRAIN : IDLE) :
                    cur == DRAIN ? (occ_n == 2'd0 ? IDLE : DRAIN) : IDLE;
    end
    always_ff @(posedge clk) begin
        if (!reset) begin
            cur       <= IDLE;
            occ       <= 2'd0;
            pend      <= 1'b0;
            head      <= '0;
            tail      <= '0;
            pop_count <= 8'd0;
        end else begin
            cur       <= nxt;
            occ       <= occ_n;
            pend      <= fifo_rd;
            head      <= head_n;
            tail      <= tail_n;
            pop_count <= pop_count + {7'd0, xfer};
        end
    end
endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// tb_fifo_rd_ctrl: directed self-checking bench with a 1-cycle-latency FIFO model
module tb_fifo_rd_ctrl;
    logic       clk = 1'b0;
    logic       reset, en, out_ready;
    logic       fifo_empty, fifo_rd, out_valid;
    logic [7:0] fifo_data = 8'd0;
    logic [7:0] out_data, pop_count;
    logic [1:0] state;
    logic [7:0] mem [0:511];
    int         wptr = 0;
    int         rptr = 0;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    fifo_rd_ctrl #(.DATA_WIDTH(8)) dut (
        .clk(clk), .reset(reset), .en(en), .fifo_empty(fifo_empty),
        .fifo_data(fifo_data), .fifo_rd(fifo_rd), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .pop_count(pop_count),
        .state(state)
    );

    assign fifo_empty = (rptr == wptr);

    always @(posedge clk) begin
        if (fifo_rd) begin
            fifo_data <= mem[rptr];
            rptr      <= rptr + 1;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [7:0] v);
        mem[wptr] = v;
        wptr = wptr + 1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        reset = 1'b0; en = 1'b0; out_ready = 1'b0;
        tick(); tick();
        chk("rst_state", 32'(state), 0);
        chk("rst_valid", 32'(out_valid), 0);
        chk("rst_data", 32'(out_data), 0);
        chk("rst_pop", 32'(pop_count), 0);
        chk("rst_rd", 32'(fifo_rd), 0);
        // streaming 1..8
        for (int i = 1; i <= 8; i++) push(8'(i));
        reset = 1'b1; en = 1'b1; out_ready = 1'b1;
        tick();
        chk("run_state", 32'(state), 1);
        chk("start_rd", 32'(fifo_rd), 1);
        chk("start_valid", 32'(out_valid), 0);
        tick();
        chk("lat_valid", 32'(out_valid), 0);
        tick();
        for (int k = 1; k <= 8; k++) begin
            chk("stream_data", 32'(out_data), 32'(k));
            chk("stream_valid", 32'(out_valid), 1);
            tick();
        end
        chk("stream_pop", 32'(pop_count), 8);
        chk("stream_end_valid", 32'(out_valid), 0);
        chk("stream_end_rd", 32'(fifo_rd), 0);
        // empty FIFO while enabled
        tick(); tick();
        chk("empty_rd", 32'(fifo_rd), 0);
        chk("empty_valid", 32'(out_valid), 0);
        chk("empty_state", 32'(state), 1);
        // backpressure
        for (int i = 0; i < 8; i++) push(8'(8'h10 + i));
        tick(); tick();
        chk("bp_head", 32'(out_data), 32'h10);
        out_ready = 1'b0;
        #1;
        chk("bp_rd_stall", 32'(fifo_rd), 0);
        repeat (4) begin
            tick();
            chk("bp_frozen_data", 32'(out_data), 32'h10);
            chk("bp_frozen_rd", 32'(fifo_rd), 0);
            chk("bp_frozen_valid", 32'(out_valid), 1);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_resume_rd", 32'(fifo_rd), 1);
        for (int k = 0; k < 8; k++) begin
            chk("bp_order", 32'(out_data), 32'(8'h10 + k));
            chk("bp_valid", 32'(out_valid), 1);
            tick();
        end
        chk("bp_pop", 32'(pop_count), 16);
        chk("bp_end_valid", 32'(out_valid), 0);
        // drain with two words buffered
        out_ready = 1'b0;
        for (int i = 0; i < 6; i++) push(8'(8'h20 + i));
        tick(); tick(); tick();
        en = 1'b0;
        #1;
        chk("drain_rd0", 32'(fifo_rd), 0);
        tick();
        chk("drain_state", 32'(state), 2);
        chk("drain_rd1", 32'(fifo_rd), 0);
        chk("drain_head", 32'(out_data), 32'h20);
        out_ready = 1'b1;
        tick();
        chk("drain_state2", 32'(state), 2);
        chk("drain_second", 32'(out_data), 32'h21);
        chk("drain_rd2", 32'(fifo_rd), 0);
        tick();
        chk("drain_idle", 32'(state), 0);
        chk("drain_valid", 32'(out_valid), 0);
        chk("drain_pop", 32'(pop_count), 18);
        // reset with one word buffered and one capture pending
        en = 1'b1; out_ready = 1'b0;
        tick();
        chk("mr_run", 32'(state), 1);
        tick(); tick();
        chk("mr_pre_head", 32'(out_data), 32'h22);
        reset = 1'b0;
        #1;
        chk("mr_gate_rd", 32'(fifo_rd), 0);
        chk("mr_gate_valid", 32'(out_valid), 0);
        chk("mr_gate_data", 32'(out_data), 0);
        tick();
        chk("mr_state", 32'(state), 0);
        chk("mr_pop", 32'(pop_count), 0);
        chk("mr_valid", 32'(out_valid), 0);
        reset = 1'b1; out_ready = 1'b1;
        tick();
        chk("mr_rel_valid", 32'(out_valid), 0);
        chk("mr_rel_state", 32'(state), 1);
        tick();
        chk("mr_rel_valid2", 32'(out_valid), 0);
        tick();
        chk("mr_fresh_data", 32'(out_data), 32'h24);
        chk("mr_fresh_valid", 32'(out_valid), 1);
        tick();
        chk("mr_fresh_data2", 32'(out_data), 32'h25);
        tick();
        chk("mr_end_valid", 32'(out_valid), 0);
        chk("mr_end_pop", 32'(pop_count), 2);
        // pop_count wrap over 257 transfers
        reset = 1'b0;
        tick();
        for (int i = 0; i < 257; i++) push(8'(i));
        reset = 1'b1;
        repeat (259) tick();
        chk("wrap_pop0", 32'(pop_count), 0);
        chk("wrap_last_valid", 32'(out_valid), 1);
        chk("wrap_last_data", 32'(out_data), 0);
        tick();
        chk("wrap_pop1", 32'(pop_count), 1);
        chk("wrap_end_valid", 32'(out_valid), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
